// File: rtl/hdb3_link_tester_if.sv
// Stream bundle between the PCM/HDB3 loopback chain and the link tester:
// source samples going into the chain and decoded words coming back out.
interface hdb3_link_tester_if;
   logic       src_valid;
   logic [7:0] src_data;
   logic       dec_valid;
   logic [7:0] dec_data;

   modport master (
      output src_valid,
      output src_data,
      output dec_valid,
      output dec_data
   );

   modport slave (
      input src_valid,
      input src_data,
      input dec_valid,
      input dec_data
   );
endinterface

// File: rtl/hdb3_link_tester.sv
// Loopback BER tester for the PCM/HDB3 chain: flushes the chain, searches for the
// word alignment between source and decoder, then counts mismatches over a test run.
module hdb3_link_tester #(
   parameter int TEST_FRAMES  = 256,
   parameter int FLUSH_CYCLES = 64,
   parameter int SYNC_TIMEOUT = 512
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   hdb3_link_tester_if.slave   link,
   output logic                chain_en,
   output logic                busy,
   output logic                lock,
   output logic [3:0]          latency,
   output logic                done,
   output logic                pass,
   output logic [15:0]         err_count,
   output logic [15:0]         frame_count
);

   localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int SYNC_W  = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      SYNC,
      RUN,
      DONE
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [7:0]         history [16];
   logic [3:0]         wr_ptr;
   logic [3:0]         k;
   logic [1:0]         match_run;
   logic [3:0]         miss_run;
   logic [FLUSH_W-1:0] flush_cnt;
   logic [SYNC_W-1:0]  sync_cnt;

   logic [3:0]         ref_idx;
   logic [7:0]         ref_byte;
   logic               is_match;
   logic               lock_hit;
   logic               pass_next;
   logic [15:0]        err_next;
   logic [3:0]         miss_next;
   logic               hist_wr;

   assign chain_en = (state == FLUSH) || (state == SYNC) || (state == RUN);
   assign busy     = (state != IDLE) && (state != DONE);
   assign lock     = (state == RUN);
   assign hist_wr  = chain_en && link.src_valid;

   // The reference is taken from the pointer before any same-cycle write, so a
   // coincident source sample never compares against itself.
   always_comb begin
      ref_idx    = wr_ptr - 4'd1 - ((state == RUN) ? latency : k);
      ref_byte   = history[ref_idx];
      is_match   = (link.dec_data == ref_byte);
      lock_hit   = (state == SYNC) && link.dec_valid && is_match && (match_run == 2'd2);
      state_next = state;
      pass_next  = pass;
      err_next   = err_count;
      miss_next  = miss_run;

      if ((state == RUN) && link.dec_valid) begin
         if (is_match) begin
            miss_next = 4'd0;
         end else begin
            miss_next = miss_run + 4'd1;
            if (err_count != 16'hFFFF) begin
               err_next = err_count + 16'd1;
            end
         end
      end

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = FLUSH;
               pass_next  = 1'b0;
            end
         end
         FLUSH: begin
            if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
               state_next = SYNC;
            end
         end
         SYNC: begin
            if (link.dec_valid) begin
               if (lock_hit) begin
                  state_next = RUN;
               end else if (sync_cnt == SYNC_W'(SYNC_TIMEOUT - 1)) begin
                  state_next = DONE;
                  pass_next  = 1'b0;
               end
            end
         end
         RUN: begin
            if (link.dec_valid) begin
               if (miss_next == 4'd8) begin
                  state_next = DONE;
                  pass_next  = 1'b0;
               end else if ((frame_count + 16'd1) == 16'(TEST_FRAMES)) begin
                  state_next = DONE;
                  pass_next  = (err_next == 16'd0);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (abort) begin
         state_next = IDLE;
         pass_next  = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pass  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         pass  <= pass_next;
         done  <= (state_next == DONE) && (state != DONE);
      end
   end

   // Counters freeze on abort so the last run can still be inspected from IDLE.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count   <= 16'd0;
         frame_count <= 16'd0;
         latency     <= 4'd0;
         wr_ptr      <= 4'd0;
         k           <= 4'd0;
         match_run   <= 2'd0;
         miss_run    <= 4'd0;
         flush_cnt   <= '0;
         sync_cnt    <= '0;
      end else begin
         if (hist_wr) begin
            wr_ptr <= wr_ptr + 4'd1;
         end
         if (!abort) begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     err_count   <= 16'd0;
                     frame_count <= 16'd0;
                     latency     <= 4'd0;
                     wr_ptr      <= 4'd0;
                     k           <= 4'd0;
                     flush_cnt   <= '0;
                  end
               end
               FLUSH: begin
                  flush_cnt <= flush_cnt + FLUSH_W'(1);
                  if (state_next == SYNC) begin
                     k         <= 4'd0;
                     match_run <= 2'd0;
                     sync_cnt  <= '0;
                  end
               end
               SYNC: begin
                  if (link.dec_valid) begin
                     sync_cnt <= sync_cnt + SYNC_W'(1);
                     if (is_match) begin
                        if (lock_hit) begin
                           latency  <= k;
                           miss_run <= 4'd0;
                        end else begin
                           match_run <= match_run + 2'd1;
                        end
                     end else begin
                        match_run <= 2'd0;
                        k         <= k + 4'd1;
                     end
                  end
               end
               RUN: begin
                  if (link.dec_valid) begin
                     frame_count <= frame_count + 16'd1;
                     err_count   <= err_next;
                     miss_run    <= miss_next;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // History contents carry no reset; the flush phase refills them before use.
   always_ff @(posedge sys_clk) begin
      if (hist_wr) begin
         history[wr_ptr] <= link.src_data;
      end
   end

endmodule

// File: tb/tb_hdb3_link_tester.sv
// Randomized loopback bench: an event-level model of the tester predicts status every
// cycle and queues the expected result of each test, popped when done pulses.
module tb_hdb3_link_tester;

   localparam int TEST_FRAMES  = 256;
   localparam int FLUSH_CYCLES = 64;
   localparam int SYNC_TIMEOUT = 512;

   localparam int P_IDLE  = 0;
   localparam int P_FLUSH = 1;
   localparam int P_SYNC  = 2;
   localparam int P_RUN   = 3;
   localparam int P_DONE  = 4;

   localparam int M_CLEAN   = 0;
   localparam int M_CORRUPT = 1;
   localparam int M_CONST   = 2;
   localparam int M_STUCK   = 3;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic        abort   = 1'b0;
   logic        chain_en, busy, lock, done, pass;
   logic [3:0]  latency;
   logic [15:0] err_count, frame_count;

   hdb3_link_tester_if link ();

   hdb3_link_tester #(
      .TEST_FRAMES (TEST_FRAMES),
      .FLUSH_CYCLES(FLUSH_CYCLES),
      .SYNC_TIMEOUT(SYNC_TIMEOUT)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .link       (link),
      .chain_en   (chain_en),
      .busy       (busy),
      .lock       (lock),
      .latency    (latency),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .frame_count(frame_count)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit pass;
      int err;
      int frames;
      int lat;
   } result_t;

   result_t    exp_q [$];
   result_t    popped;
   int         n_checks = 0;
   int         n_fail   = 0;

   int         m_phase = P_IDLE;
   int         m_flush = 0, m_k = 0, m_run = 0, m_strobes = 0;
   int         m_lat = 0, m_err = 0, m_frames = 0, m_miss = 0;
   bit         m_done_pulse = 1'b0;
   logic [7:0] m_hist [$];

   task automatic checkOutput(input string name, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Byte the source produced k words before the most recent one.
   function automatic logic [7:0] m_ref(input int k);
      if (m_hist.size() < k + 1) return 8'h00;
      return m_hist[m_hist.size() - 1 - k];
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_flush = 0; m_k = 0; m_run = 0; m_strobes = 0;
      m_lat = 0; m_err = 0; m_frames = 0; m_miss = 0;
      m_done_pulse = 1'b0;
   endtask

   task automatic model_finish(input bit p);
      m_phase = P_DONE;
      m_done_pulse = 1'b1;
      exp_q.push_back('{p, m_err, m_frames, m_lat});
   endtask

   task automatic model_step(input bit st, input bit ab, input bit sv, input logic [7:0] sd,
                             input bit dv, input logic [7:0] dd);
      m_done_pulse = 1'b0;
      if (ab) begin
         m_phase = P_IDLE;
         return;
      end
      case (m_phase)
         P_IDLE, P_DONE: begin
            if (st) begin
               m_phase = P_FLUSH;
               m_flush = 0; m_err = 0; m_frames = 0; m_lat = 0;
               m_hist.delete();
            end
         end
         P_FLUSH: begin
            if (sv) m_hist.push_back(sd);
            m_flush++;
            if (m_flush == FLUSH_CYCLES) begin
               m_phase = P_SYNC;
               m_k = 0; m_run = 0; m_strobes = 0;
            end
         end
         P_SYNC: begin
            if (dv) begin
               m_strobes++;
               if (dd == m_ref(m_k)) begin
                  m_run++;
                  if (m_run == 3) begin
                     m_lat = m_k;
                     m_miss = 0;
                     m_phase = P_RUN;
                  end
               end else begin
                  m_run = 0;
                  m_k = (m_k + 1) % 16;
               end
               if (m_phase == P_SYNC && m_strobes == SYNC_TIMEOUT) model_finish(1'b0);
            end
            if (sv) m_hist.push_back(sd);
         end
         P_RUN: begin
            if (dv) begin
               m_frames++;
               if (dd == m_ref(m_lat)) begin
                  m_miss = 0;
               end else begin
                  m_miss++;
                  if (m_err < 65535) m_err++;
               end
               if (m_miss == 8) model_finish(1'b0);
               else if (m_frames == TEST_FRAMES) model_finish(m_err == 0);
            end
            if (sv) m_hist.push_back(sd);
         end
         default: begin
         end
      endcase
   endtask

   task automatic applyStimulus(input bit st, input bit ab, input bit sv, input logic [7:0] sd,
                                input bit dv, input logic [7:0] dd);
      start          = st;
      abort          = ab;
      link.src_valid = sv;
      link.src_data  = sd;
      link.dec_valid = dv;
      link.dec_data  = dd;
      @(posedge sys_clk);
      #1;
      model_step(st, ab, sv, sd, dv, dd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   // One full test: the decoder echoes the source with word latency lat, bent by mode.
   task automatic run_test(input int mode, input int lat, input bit coinc, input int event_at,
                           input bit do_abort);
      bit ended;
      bit corrupted;
      ended = 1'b0;
      corrupted = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      for (int n = 0; n < 20000; n++) begin
         bit         sv, dv, ab, st;
         logic [7:0] sd, dd;
         if (m_phase == P_DONE || m_phase == P_IDLE) begin
            ended = 1'b1;
            break;
         end
         sd = 8'($urandom_range(0, 127));
         if (m_phase == P_FLUSH) sv = (n % 2 == 0) || ($urandom_range(0, 1) == 1);
         else sv = ($urandom_range(0, 3) != 0);
         dv = coinc ? sv : ($urandom_range(0, 1) == 1);
         st = ($urandom_range(0, 99) == 0);
         ab = 1'b0;
         dd = 8'($urandom);
         if (m_phase == P_SYNC || m_phase == P_RUN) dd = m_ref(lat);
         if (mode == M_CONST) dd = 8'hA5;
         if (mode == M_CORRUPT && m_phase == P_RUN && dv && !corrupted && m_frames == event_at) begin
            dd = dd ^ 8'h80;
            corrupted = 1'b1;
         end
         if (mode == M_STUCK && m_phase == P_RUN && m_frames >= event_at) dd = 8'hFF;
         if (do_abort && m_phase == P_RUN && m_frames == event_at) begin
            ab = 1'b1;
            dv = 1'b0;
         end
         applyStimulus(st, ab, sv, sd, dv, dd);
      end
      if (!ended) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL test_budget: test mode %0d did not end, required end within budget", mode);
      end
   endtask

   always @(negedge sys_clk) begin
      checkOutput("status",
                  {chain_en, busy, lock, done, latency, err_count, frame_count},
                  {(m_phase == P_FLUSH || m_phase == P_SYNC || m_phase == P_RUN),
                   (m_phase == P_FLUSH || m_phase == P_SYNC || m_phase == P_RUN),
                   (m_phase == P_RUN), m_done_pulse, 4'(m_lat), 16'(m_err), 16'(m_frames)});
   end

   always @(negedge sys_clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_unexpected: got done=1, required no result pending");
         end else begin
            popped = exp_q.pop_front();
            checkOutput("done_pass", pass, popped.pass);
            checkOutput("done_err", err_count, popped.err);
            checkOutput("done_frames", frame_count, popped.frames);
            checkOutput("done_latency", latency, popped.lat);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      link.src_valid = 1'b0;
      link.src_data  = 8'h00;
      link.dec_valid = 1'b0;
      link.dec_data  = 8'h00;
      model_reset();
      idle(3);
      checkOutput("reset_pass", pass, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_chain_en", chain_en, 0);
      rst_n = 1'b1;
      idle(2);

      run_test(M_CLEAN, 2, 1'b0, 0, 1'b0);
      idle(3);
      for (int i = 0; i < 3; i++) begin
         run_test(M_CLEAN, $urandom_range(0, 15), 1'b0, 0, 1'b0);
         idle(3);
      end
      run_test(M_CORRUPT, 2, 1'b0, 50, 1'b0);
      idle(3);
      run_test(M_CONST, 2, 1'b0, 0, 1'b0);
      idle(3);
      run_test(M_STUCK, 2, 1'b0, 10, 1'b0);
      idle(3);

      run_test(M_CLEAN, 2, 1'b0, 100, 1'b1);
      checkOutput("abort_frames_hold", frame_count, 100);
      checkOutput("abort_chain_en", chain_en, 0);
      idle(3);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      checkOutput("restart_clears_frames", frame_count, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      idle(2);

      run_test(M_CLEAN, 0, 1'b1, 0, 1'b0);
      idle(3);

      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      idle(10);
      rst_n = 1'b0;
      model_reset();
      #1;
      checkOutput("async_reset_chain_en", chain_en, 0);
      idle(2);
      rst_n = 1'b1;
      idle(5);
      checkOutput("post_reset_busy", busy, 0);

      checkOutput("results_pending", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
